pipeline_ex_stage: RTL and testbench
====================================

Name: pipeline_ex_stage

Overview:
Parametrised, registered execute stage between decode and memory. Accepts one decoded instruction per valid/ready handshake and evaluates ALU ops, branches and jumps. A multi-cycle MUL path is included. Outputs are held in an output register toward the MEM stage, with full backpressure. Taken branches and jumps produce a registered one-cycle redirect pulse to fetch.

Parameters:
ADDR_WIDTH, 64, PC / jump target width
DATA_WIDTH, 64, operand and result width
IMM_WIDTH, 21, signed immediate width; sign-extended to DATA_WIDTH / ADDR_WIDTH
MUL_CYCLES, 4, cycles spent in BUSY for MUL (range 1..DATA_WIDTH)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage accepts this cycle
op  in  5  ex_op_t operation code
instruction_pc  in  ADDR_WIDTH  PC of the instruction
r1_val  in  DATA_WIDTH  source 1
r2_val  in  DATA_WIDTH  source 2
imm  in  IMM_WIDTH  signed immediate
imm_or_reg2  in  1  1 = ALU operand B is imm, 0 = r2_val
dst_reg  in  5  destination register
mem_opcode  in  32  passed through to MEM
is_mem_load  in  1  passed through to MEM
out_valid  out  1  output register holds a result
out_ready  in  1  MEM stage accepts
ex_res  out  DATA_WIDTH  result (ALU result, link address, or address for mem ops)
r2_val_mem  out  DATA_WIDTH  store data
mem_dst_reg  out  5  destination register
next_mem_opcode  out  32  registered mem_opcode
next_is_mem_load  out  1  registered is_mem_load
jump_signal  out  1  one-cycle redirect pulse
jump_pc  out  ADDR_WIDTH  redirect target, valid while jump_signal=1

Behaviour:
- Clock is clk; reset is synchronous, active-high. On reset: state EMPTY; out_valid=0; jump_signal=0; jump_pc, ex_res, r2_val_mem, mem_dst_reg, next_mem_opcode, next_is_mem_load, and the MUL counter all 0.
- Reset during BUSY aborts the MUL with no output.
- Operand B = imm_or_reg2 ? sext(imm) : r2_val.
- Ops:
  - NOP=0, ADD, SUB, AND, OR, XOR.
  - SLL/SRL/SRA: shift amount = B[$clog2(DATA_WIDTH)-1:0].
  - SLT (signed) and SLTU: result is 1 or 0.
  - MUL: low DATA_WIDTH bits of r1*B.
  - BEQ, BNE, BLT (signed), compare r1_val vs r2_val.
  - JAL, JALR.
- Branch target is instruction_pc + sext(imm). JALR target is (r1_val + sext(imm)) with bit0 cleared.
- JAL/JALR: ex_res = instruction_pc + 4. Branches: ex_res = 0. Unknown op codes behave as NOP.
- Accept condition: in_valid && in_ready.
  - in_ready = (state==EMPTY) || (state==FULL && out_ready).
  - in_ready is 0 in BUSY.
- State machine:
  - EMPTY: on accept of a non-MUL op -> FULL, outputs registered next edge (latency 1). On accept of MUL -> BUSY, counter = MUL_CYCLES-1.
  - BUSY: counter decrements each cycle. At 0 the result is written -> FULL, giving total latency MUL_CYCLES+1 cycles from accept to out_valid.
  - FULL: out_valid=1, outputs stable until out_ready. If out_ready && accept: back-to-back (stays FULL, or goes to BUSY for MUL). If out_ready && !accept -> EMPTY.
- NOP (op=0) is accepted and consumed without occupying the output register. in_ready for NOP follows the same rule; the state is unchanged except FULL+out_ready -> EMPTY.
- jump_signal is registered: asserted for exactly one cycle, on the edge following acceptance of a taken branch, JAL or JALR. jump_pc is loaded at the same edge; jump_pc holds its value otherwise.
- jump_signal never asserts for MUL, NOP, or not-taken branches.
- Two consecutive accepted jumps produce two consecutive pulses.
- All arithmetic wraps modulo 2^DATA_WIDTH / 2^ADDR_WIDTH.
- No output changes while FULL && !out_ready (hold under stall).

Decomposition:
- Package ex_pkg: typedef enum logic [4:0] ex_op_t holding all op codes; state typedef (EMPTY, BUSY, FULL); constant PC_STEP=4.
- Sub-module ex_alu: purely combinational; (op, a, b, pc) -> result, branch_taken, target.
- The MUL counter and FSM live in pipeline_ex_stage.

Test Plan:
- ADD reg: r1=5, r2=7, imm_or_reg2=0, out_ready=1 -> next cycle out_valid=1, ex_res=12, jump_signal=0.
- Stall: SUB r1=10, imm=-3 accepted with out_ready=0 for 3 cycles -> ex_res=13 held, in_ready=0 while held. out_ready=1 -> back-to-back accept of the next op the same cycle.
- MUL: r1=6, r2=7, MUL_CYCLES=4 -> in_ready=0 for 4 cycles, out_valid on cycle 5 with ex_res=42. Reset asserted mid-BUSY -> out_valid=0 and in_ready=1 the following cycle.
- BEQ taken: pc=0x100, r1=r2=3, imm=0x20 -> jump_signal high exactly one cycle with jump_pc=0x120. BNE same operands -> no pulse.
- JALR: pc=0x200, r1=0x1003, imm=4 -> jump_pc=0x1006, ex_res=0x204, jump_signal 1 cycle.
- Reset: assert reset with FULL and jump pending -> all outputs 0 next cycle; mem_opcode/is_mem_load pass-through verified as 0 after reset, then as input values after the next accept.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared types for the execute stage: op codes, FSM states and the
// helper that decides which ops occupy the output register.
package ex_pkg;

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,
        OP_ADD  = 5'd1,
        OP_SUB  = 5'd2,
        OP_AND  = 5'd3,
        OP_OR   = 5'd4,
        OP_XOR  = 5'd5,
        OP_SLL  = 5'd6,
        OP_SRL  = 5'd7,
        OP_SRA  = 5'd8,
        OP_SLT  = 5'd9,
        OP_SLTU = 5'd10,
        OP_MUL  = 5'd11,
        OP_BEQ  = 5'd12,
        OP_BNE  = 5'd13,
        OP_BLT  = 5'd14,
        OP_JAL  = 5'd15,
        OP_JALR = 5'd16
    } ex_op_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } ex_state_t;

    localparam int PC_STEP = 4;

    // NOP and unknown encodings are consumed without producing a result.
    function automatic logic occupies_out(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_JALR);
    endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU / branch unit: single-cycle ops, branch decision and
// redirect target. MUL is handled by the multi-cycle path in the stage.
module ex_alu
    import ex_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic [4:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] r2,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] imm_a,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  branch_taken,
    output logic [ADDR_WIDTH-1:0] target
);
    localparam int SHW = $clog2(DATA_WIDTH);

    logic [SHW-1:0]        shamt;
    logic [ADDR_WIDTH-1:0] jalr_sum;
    logic [DATA_WIDTH-1:0] link;

    assign shamt    = b[SHW-1:0];
    assign jalr_sum = ADDR_WIDTH'(a) + imm_a;
    assign link     = DATA_WIDTH'(pc + ADDR_WIDTH'(PC_STEP));

    always_comb begin
        result       = '0;
        branch_taken = 1'b0;
        target       = pc + imm_a;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $signed(a) >>> shamt;
            OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            OP_BEQ:  branch_taken = (a == r2);
            OP_BNE:  branch_taken = (a != r2);
            OP_BLT:  branch_taken = ($signed(a) < $signed(r2));
            OP_JAL: begin
                branch_taken = 1'b1;
                result       = link;
            end
            OP_JALR: begin
                branch_taken = 1'b1;
                result       = link;
                target       = {jalr_sum[ADDR_WIDTH-1:1], 1'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipeline_ex_stage.sv
// Registered execute stage: valid/ready in, held output register toward MEM,
// multi-cycle MUL path and a registered one-cycle redirect pulse to fetch.
module pipeline_ex_stage
    import ex_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int IMM_WIDTH  = 21,
    parameter int MUL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            op,
    input  logic [ADDR_WIDTH-1:0] instruction_pc,
    input  logic [DATA_WIDTH-1:0] r1_val,
    input  logic [DATA_WIDTH-1:0] r2_val,
    input  logic [IMM_WIDTH-1:0]  imm,
    input  logic                  imm_or_reg2,
    input  logic [4:0]            dst_reg,
    input  logic [31:0]           mem_opcode,
    input  logic                  is_mem_load,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ex_res,
    output logic [DATA_WIDTH-1:0] r2_val_mem,
    output logic [4:0]            mem_dst_reg,
    output logic [31:0]           next_mem_opcode,
    output logic                  next_is_mem_load,
    output logic                  jump_signal,
    output logic [ADDR_WIDTH-1:0] jump_pc
);
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    ex_state_t             state, state_nxt;
    logic [CW-1:0]         mul_cnt;
    logic [DATA_WIDTH-1:0] imm_d, op_b, alu_res, mul_a, mul_b, mul_res, pend_r2;
    logic [ADDR_WIDTH-1:0] imm_a, alu_tgt;
    logic [4:0]            pend_dst;
    logic [31:0]           pend_opcode;
    logic                  pend_load;
    logic                  alu_taken, accept, is_mul, occupies, mul_done;

    assign imm_d = {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    assign imm_a = {{(ADDR_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    assign op_b  = imm_or_reg2 ? imm_d : r2_val;

    assign in_ready  = (state == EMPTY) || (state == FULL && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (op == OP_MUL);
    assign occupies  = occupies_out(op);
    assign mul_done  = (state == BUSY) && (mul_cnt == '0);
    assign mul_res   = mul_a * mul_b;
    assign out_valid = (state == FULL);

    ex_alu #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .op          (op),
        .a           (r1_val),
        .b           (op_b),
        .r2          (r2_val),
        .pc          (instruction_pc),
        .imm_a       (imm_a),
        .result      (alu_res),
        .branch_taken(alu_taken),
        .target      (alu_tgt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept && occupies) state_nxt = is_mul ? BUSY : FULL;
            BUSY:  if (mul_done) state_nxt = FULL;
            FULL: begin
                if (accept && occupies) state_nxt = is_mul ? BUSY : FULL;
                else if (out_ready)     state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= EMPTY;
            mul_cnt          <= '0;
            mul_a            <= '0;
            mul_b            <= '0;
            pend_r2          <= '0;
            pend_dst         <= '0;
            pend_opcode      <= '0;
            pend_load        <= 1'b0;
            ex_res           <= '0;
            r2_val_mem       <= '0;
            mem_dst_reg      <= '0;
            next_mem_opcode  <= '0;
            next_is_mem_load <= 1'b0;
            jump_signal      <= 1'b0;
            jump_pc          <= '0;
        end else begin
            state       <= state_nxt;
            jump_signal <= accept && alu_taken;
            if (accept && alu_taken) jump_pc <= alu_tgt;

            // MUL side-band fields are parked until the product is written.
            if (accept && occupies && is_mul) begin
                mul_cnt     <= CW'(MUL_CYCLES - 1);
                mul_a       <= r1_val;
                mul_b       <= op_b;
                pend_r2     <= r2_val;
                pend_dst    <= dst_reg;
                pend_opcode <= mem_opcode;
                pend_load   <= is_mem_load;
            end else if (state == BUSY && !mul_done) begin
                mul_cnt <= mul_cnt - CW'(1);
            end

            if (accept && occupies && !is_mul) begin
                ex_res           <= alu_res;
                r2_val_mem       <= r2_val;
                mem_dst_reg      <= dst_reg;
                next_mem_opcode  <= mem_opcode;
                next_is_mem_load <= is_mem_load;
            end else if (mul_done) begin
                ex_res           <= mul_res;
                r2_val_mem       <= pend_r2;
                mem_dst_reg      <= pend_dst;
                next_mem_opcode  <= pend_opcode;
                next_is_mem_load <= pend_load;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ex_stage.sv
// Bench for pipeline_ex_stage: vector table through a result scoreboard,
// plus directed sequences for stall, MUL latency, reset and redirect pulses.
module tb_pipeline_ex_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, imm_or_reg2, is_mem_load;
    logic [4:0]  op, dst_reg, mem_dst_reg;
    logic [63:0] instruction_pc, r1_val, r2_val, ex_res, r2_val_mem, jump_pc;
    logic [20:0] imm;
    logic [31:0] mem_opcode, next_mem_opcode;
    logic        out_valid, out_ready, next_is_mem_load, jump_signal;

    always #5 clk = ~clk;

    pipeline_ex_stage #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .IMM_WIDTH(21), .MUL_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .instruction_pc(instruction_pc), .r1_val(r1_val), .r2_val(r2_val),
        .imm(imm), .imm_or_reg2(imm_or_reg2), .dst_reg(dst_reg),
        .mem_opcode(mem_opcode), .is_mem_load(is_mem_load),
        .out_valid(out_valid), .out_ready(out_ready), .ex_res(ex_res),
        .r2_val_mem(r2_val_mem), .mem_dst_reg(mem_dst_reg),
        .next_mem_opcode(next_mem_opcode), .next_is_mem_load(next_is_mem_load),
        .jump_signal(jump_signal), .jump_pc(jump_pc)
    );

    typedef struct {
        logic [4:0]  op;
        logic [63:0] pc, r1, r2;
        logic [20:0] imm;
        logic        sel, has_out;
        logic [63:0] res;
        logic        jmp;
        logic [63:0] jpc;
    } vec_t;

    typedef struct {
        logic [63:0] res, r2;
        logic [4:0]  dst;
        logic [31:0] opc;
        logic        ld;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    bit   sb_on = 1'b0;
    exp_t sbq[$];
    exp_t mon_e;
    vec_t tv[22];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] o, input logic [63:0] pc, r1, r2,
                                input logic [20:0] im, input logic s, h,
                                input logic [63:0] res, input logic j, input logic [63:0] jp);
        vec_t v;
        v.op = o; v.pc = pc; v.r1 = r1; v.r2 = r2; v.imm = im; v.sel = s;
        v.has_out = h; v.res = res; v.jmp = j; v.jpc = jp;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] o, input logic [63:0] pc, r1, r2,
                         input logic [20:0] im, input logic s);
        op = o; instruction_pc = pc; r1_val = r1; r2_val = r2; imm = im; imm_or_reg2 = s;
    endtask

    // Present one vector, wait (bounded) for the handshake, queue its expected result.
    task automatic send(input vec_t v, input int idx);
        bit   got = 1'b0;
        exp_t e;
        drive(v.op, v.pc, v.r1, v.r2, v.imm, v.sel);
        dst_reg     = idx[4:0];
        mem_opcode  = 32'hA500_0000 | 32'(idx);
        is_mem_load = idx[0];
        in_valid    = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                if (v.has_out) begin
                    e.res = v.res; e.r2 = v.r2; e.dst = idx[4:0];
                    e.opc = 32'hA500_0000 | 32'(idx); e.ld = idx[0];
                    sbq.push_back(e);
                end
            end
        end
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("vec_jump_signal", {63'd0, jump_signal}, {63'd0, v.jmp});
        if (v.jmp) chk("vec_jump_pc", jump_pc, v.jpc);
    endtask

    always @(negedge clk) begin
        if (sb_on && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_spurious_out", {63'd0, out_valid}, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_ex_res", ex_res, mon_e.res);
                chk("sb_r2_val_mem", r2_val_mem, mon_e.r2);
                chk("sb_dst", {59'd0, mem_dst_reg}, {59'd0, mon_e.dst});
                chk("sb_opcode", {32'd0, next_mem_opcode}, {32'd0, mon_e.opc});
                chk("sb_load", {63'd0, next_is_mem_load}, {63'd0, mon_e.ld});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = mk(OP_ADD,  0, 5, 7, 0, 0, 1, 64'd12, 0, 0);
        tv[1]  = mk(OP_SUB,  0, 10, 0, 21'h1FFFFD, 1, 1, 64'd13, 0, 0);
        tv[2]  = mk(OP_AND,  0, 64'hF0F0, 64'hFF00, 0, 0, 1, 64'hF000, 0, 0);
        tv[3]  = mk(OP_OR,   0, 64'hF0F0, 64'hFF00, 0, 0, 1, 64'hFFF0, 0, 0);
        tv[4]  = mk(OP_XOR,  0, 64'hF0F0, 64'hFF00, 0, 0, 1, 64'h0FF0, 0, 0);
        tv[5]  = mk(OP_SLL,  0, 1, 65, 0, 0, 1, 64'd2, 0, 0);
        tv[6]  = mk(OP_SRL,  0, 64'h8000_0000_0000_0000, 0, 21'd63, 1, 1, 64'd1, 0, 0);
        tv[7]  = mk(OP_SRA,  0, 64'h8000_0000_0000_0000, 63, 0, 0, 1, '1, 0, 0);
        tv[8]  = mk(OP_SLT,  0, '1, 1, 0, 0, 1, 64'd1, 0, 0);
        tv[9]  = mk(OP_SLTU, 0, '1, 1, 0, 0, 1, 64'd0, 0, 0);
        tv[10] = mk(OP_ADD,  0, '1, 0, 21'd1, 1, 1, 64'd0, 0, 0);
        tv[11] = mk(OP_MUL,  0, 6, 7, 0, 0, 1, 64'd42, 0, 0);
        tv[12] = mk(OP_MUL,  0, '1, 0, 21'h1FFFFF, 1, 1, 64'd1, 0, 0);
        tv[13] = mk(OP_BEQ,  64'h100, 3, 3, 21'h20, 0, 1, 64'd0, 1, 64'h120);
        tv[14] = mk(OP_BNE,  64'h100, 3, 3, 21'h20, 0, 1, 64'd0, 0, 0);
        tv[15] = mk(OP_BLT,  64'h100, -64'sd5, 2, 21'h1FFFF0, 0, 1, 64'd0, 1, 64'hF0);
        tv[16] = mk(OP_BLT,  64'h100, 5, '1, 21'h10, 0, 1, 64'd0, 0, 0);
        tv[17] = mk(OP_JAL,  64'h300, 0, 0, 21'h40, 0, 1, 64'h304, 1, 64'h340);
        tv[18] = mk(OP_JALR, 64'h200, 64'h1003, 0, 21'd4, 0, 1, 64'h204, 1, 64'h1006);
        tv[19] = mk(OP_JAL,  64'h0, 0, 0, 21'h1FFFFC, 0, 1, 64'd4, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        tv[20] = mk(OP_NOP,  64'h100, 9, 9, 21'h8, 0, 0, 64'd0, 0, 0);
        tv[21] = mk(5'd31,   64'h100, 9, 9, 21'h8, 0, 0, 64'd0, 0, 0);

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        dst_reg = 0; mem_opcode = 0; is_mem_load = 0;
        repeat (2) tick();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_jump_signal", {63'd0, jump_signal}, 64'd0);
        chk("rst_jump_pc", jump_pc, 64'd0);
        chk("rst_ex_res", ex_res, 64'd0);
        chk("rst_r2_val_mem", r2_val_mem, 64'd0);
        chk("rst_dst", {59'd0, mem_dst_reg}, 64'd0);
        chk("rst_opcode", {32'd0, next_mem_opcode}, 64'd0);
        chk("rst_load", {63'd0, next_is_mem_load}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        reset = 1'b0;

        // ADD, latency one
        drive(OP_ADD, 0, 5, 7, 0, 0); in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk("add_out_valid", {63'd0, out_valid}, 64'd1);
        chk("add_ex_res", ex_res, 64'd12);
        chk("add_jump", {63'd0, jump_signal}, 64'd0);
        tick();
        chk("add_drained", {63'd0, out_valid}, 64'd0);

        // Stall holds the result, then back-to-back accept
        out_ready = 1'b0;
        drive(OP_SUB, 0, 10, 0, 21'h1FFFFD, 1); in_valid = 1'b1;
        tick();
        drive(OP_ADD, 0, 1, 1, 0, 0);
        for (int c = 0; c < 3; c++) begin
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_ex_res", ex_res, 64'd13);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            tick();
        end
        out_ready = 1'b1; #1;
        chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
        tick(); in_valid = 1'b0;
        chk("b2b_out_valid", {63'd0, out_valid}, 64'd1);
        chk("b2b_ex_res", ex_res, 64'd2);
        tick();
        chk("b2b_drained", {63'd0, out_valid}, 64'd0);

        // Vector table through the scoreboard
        sb_on = 1'b1;
        for (int i = 0; i < 22; i++) send(tv[i], i);
        repeat (8) tick();
        sb_on = 1'b0;
        chk("sb_drain", 64'(sbq.size()), 64'd0);

        // MUL latency
        drive(OP_MUL, 0, 6, 7, 0, 0); in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("mul_busy_in_ready", {63'd0, in_ready}, 64'd0);
            chk("mul_busy_out_valid", {63'd0, out_valid}, 64'd0);
            tick();
        end
        chk("mul_out_valid", {63'd0, out_valid}, 64'd1);
        chk("mul_ex_res", ex_res, 64'd42);
        tick();

        // Reset mid-BUSY aborts the MUL
        drive(OP_MUL, 0, 3, 3, 0, 0); in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (6) tick();
        chk("abort_no_late_out", {63'd0, out_valid}, 64'd0);

        // Taken BEQ: one-cycle pulse, jump_pc holds
        drive(OP_BEQ, 64'h100, 3, 3, 21'h20, 0); in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk("beq_jump", {63'd0, jump_signal}, 64'd1);
        chk("beq_jump_pc", jump_pc, 64'h120);
        chk("beq_ex_res", ex_res, 64'd0);
        tick();
        chk("beq_pulse_end", {63'd0, jump_signal}, 64'd0);
        chk("beq_jump_pc_hold", jump_pc, 64'h120);
        drive(OP_BNE, 64'h100, 3, 3, 21'h20, 0); in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk("bne_no_jump", {63'd0, jump_signal}, 64'd0);
        tick();

        // Reset while FULL with a redirect pending
        out_ready = 1'b0;
        drive(OP_JAL, 64'h300, 0, 0, 21'h40, 0);
        mem_opcode = 32'h1234_5678; is_mem_load = 1'b1; dst_reg = 5'd9; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk("pend_jump", {63'd0, jump_signal}, 64'd1);
        chk("pend_out_valid", {63'd0, out_valid}, 64'd1);
        chk("pend_opcode", {32'd0, next_mem_opcode}, 64'h1234_5678);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("post_rst_jump", {63'd0, jump_signal}, 64'd0);
        chk("post_rst_jump_pc", jump_pc, 64'd0);
        chk("post_rst_ex_res", ex_res, 64'd0);
        chk("post_rst_r2_val_mem", r2_val_mem, 64'd0);
        chk("post_rst_dst", {59'd0, mem_dst_reg}, 64'd0);
        chk("post_rst_opcode", {32'd0, next_mem_opcode}, 64'd0);
        chk("post_rst_load", {63'd0, next_is_mem_load}, 64'd0);

        out_ready = 1'b1;
        drive(OP_ADD, 0, 2, 3, 0, 0);
        mem_opcode = 32'hDEAD_BEEF; is_mem_load = 1'b1; dst_reg = 5'd17; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk("pt_opcode", {32'd0, next_mem_opcode}, 64'hDEAD_BEEF);
        chk("pt_load", {63'd0, next_is_mem_load}, 64'd1);
        chk("pt_dst", {59'd0, mem_dst_reg}, 64'd17);
        chk("pt_r2_val_mem", r2_val_mem, 64'd3);
        chk("pt_ex_res", ex_res, 64'd5);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
